// File: rtl/spr_pkg.sv
// Shared definitions for the sharpening-apply block.
//   SPR_PIX_W    : default pixel / amount width
//   SPR_AMT_FRAC : fractional bits of the unsigned 2.10 amount
//   SPR_AMT_LAT  : default enabled-cycle lag of the amount behind its pixel
//   SPR_RND      : round-half-up constant added before the fractional shift
//   spr_state_e  : line-sequencing FSM states
//   spr_clamp    : saturate a signed value into [0, 2^w-1]
package spr_pkg;

  localparam int SPR_PIX_W    = 12;
  localparam int SPR_AMT_FRAC = 10;
  localparam int SPR_AMT_LAT  = 4;
  localparam int SPR_RND      = 1 << (SPR_AMT_FRAC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } spr_state_e;

  // Callers size the result down to their own pixel width with a cast.
  function automatic logic [31:0] spr_clamp(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< w) - 32'sd1;
    if (v < 32'sd0)
      spr_clamp = '0;
    else if (v > hi)
      spr_clamp = hi;
    else
      spr_clamp = v;
  endfunction

endpackage

// File: rtl/spr_pix_delay.sv
// Enable-gated shift delay line with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of every stage (wins over en)
//   en       : shift one position
//   d / q    : data in / data delayed by DEPTH enabled cycles
module spr_pix_delay #(
  parameter int W     = 12,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_shift
      logic [W-1:0] dly_q [DEPTH];
      logic [W-1:0] dly_d [DEPTH];

      always_comb begin
        dly_d = dly_q;
        if (clr) begin
          for (int i = 0; i < DEPTH; i++) dly_d[i] = '0;
        end else if (en) begin
          dly_d[0] = d;
          for (int i = 1; i < DEPTH; i++) dly_d[i] = dly_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign q = dly_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/spr_sharp_apply.sv
// Applies the per-pixel sharpening amount to the raw pixel stream:
// 3-tap horizontal edge delta, scaled by the 2.10 amount, added back and clamped.
//   clk, rst        : clock, asynchronous active-high reset
//   i_hs, i_vs      : line / frame active; low clears the pipeline synchronously
//   shp_en          : pipeline advance strobe
//   sharp_bypass    : pass the centre pixel through unsharpened (same latency)
//   i_pix, amout    : raw pixel, amount for the pixel AMT_LAT enabled cycles older
//   o_pix, o_valid  : result pixel and its one-cycle valid
//   o_hs, o_vs      : i_hs / i_vs delayed one cycle, free-running
//
// state | meaning
// IDLE  | blanking, nothing accepted yet on this line
// FILL  | pixels entering, pipeline not yet producing results
// RUN   | every enabled cycle emits one result
module spr_sharp_apply
  import spr_pkg::*;
#(
  parameter int PIX_W    = SPR_PIX_W,
  parameter int AMT_LAT  = SPR_AMT_LAT,
  parameter int AMT_FRAC = SPR_AMT_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             shp_en,
  input  logic             sharp_bypass,
  input  logic [PIX_W-1:0] i_pix,
  input  logic [PIX_W-1:0] amout,
  output logic [PIX_W-1:0] o_pix,
  output logic             o_valid,
  output logic             o_hs,
  output logic             o_vs
);

  localparam int D_W      = PIX_W + 1;
  localparam int PROD_W   = 2 * PIX_W + 1;
  localparam int FILL_MAX = AMT_LAT + 3;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);
  localparam logic signed [PROD_W-1:0] RND = PROD_W'(1) <<< (AMT_FRAC - 1);

  logic clr, en;
  assign clr = !i_hs || !i_vs;
  assign en  = i_hs && i_vs && shp_en;

  logic [PIX_W-1:0] next_pix;

  spr_pix_delay #(
    .W     (PIX_W),
    .DEPTH (AMT_LAT - 1)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .d   (i_pix),
    .q   (next_pix)
  );

  spr_state_e        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  logic [PIX_W-1:0]         prev_q, prev_d, ctr_q, ctr_d;
  logic signed [D_W-1:0]    d1_q, d1_d;
  logic [PIX_W-1:0]         amt1_q, amt1_d, ctr1_q, ctr1_d;
  logic signed [PROD_W-1:0] prod2_q, prod2_d;
  logic [PIX_W-1:0]         ctr2_q, ctr2_d;
  logic [PIX_W-1:0]         res3_q, res3_d;
  logic [PIX_W-1:0]         o_pix_q, o_pix_d;
  logic                     o_valid_q, o_valid_d;
  logic                     hs_q, vs_q;

  // Fill count equals the enabled-cycle index until it saturates, so the
  // cycle whose centre is the first pixel of the line is fill == AMT_LAT.
  logic                     left_edge;
  logic [PIX_W-1:0]         prev_eff;
  logic [PIX_W:0]           nb_sum, nb_half;
  logic signed [D_W-1:0]    delta;
  logic signed [PROD_W-1:0] d_ext, a_ext, rnd_sum, adj, sum3;

  always_comb begin
    left_edge = (fill_q == FILL_W'(AMT_LAT));
    prev_eff  = left_edge ? ctr_q : prev_q;
    nb_sum    = {1'b0, prev_eff} + {1'b0, next_pix};
    nb_half   = nb_sum >> 1;
    delta     = $signed({1'b0, ctr_q}) - $signed(nb_half);

    d_ext     = PROD_W'(d1_q);
    a_ext     = PROD_W'({1'b0, amt1_q});

    rnd_sum   = prod2_q + RND;
    adj       = rnd_sum >>> AMT_FRAC;
    sum3      = adj + $signed(PROD_W'({1'b0, ctr2_q}));
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (clr) begin
      state_d = IDLE;
      fill_d  = '0;
    end else if (en) begin
      fill_d = (fill_q == FILL_W'(FILL_MAX)) ? fill_q : fill_q + FILL_W'(1);
      case (state_q)
        IDLE:    state_d = (fill_d == FILL_W'(FILL_MAX)) ? RUN : FILL;
        FILL:    if (fill_d == FILL_W'(FILL_MAX)) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    prev_d    = prev_q;
    ctr_d     = ctr_q;
    d1_d      = d1_q;
    amt1_d    = amt1_q;
    ctr1_d    = ctr1_q;
    prod2_d   = prod2_q;
    ctr2_d    = ctr2_q;
    res3_d    = res3_q;
    o_pix_d   = o_pix_q;
    o_valid_d = 1'b0;
    if (clr) begin
      prev_d  = '0;
      ctr_d   = '0;
      d1_d    = '0;
      amt1_d  = '0;
      ctr1_d  = '0;
      prod2_d = '0;
      ctr2_d  = '0;
      res3_d  = '0;
      o_pix_d = '0;
    end else if (en) begin
      prev_d    = ctr_q;
      ctr_d     = next_pix;
      d1_d      = delta;
      amt1_d    = amout;
      ctr1_d    = ctr_q;
      prod2_d   = d_ext * a_ext;
      ctr2_d    = ctr1_q;
      res3_d    = sharp_bypass ? ctr2_q : PIX_W'(spr_clamp(32'(sum3), PIX_W));
      o_pix_d   = res3_q;
      o_valid_d = (state_q == RUN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      prev_q    <= '0;
      ctr_q     <= '0;
      d1_q      <= '0;
      amt1_q    <= '0;
      ctr1_q    <= '0;
      prod2_q   <= '0;
      ctr2_q    <= '0;
      res3_q    <= '0;
      o_pix_q   <= '0;
      o_valid_q <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      prev_q    <= prev_d;
      ctr_q     <= ctr_d;
      d1_q      <= d1_d;
      amt1_q    <= amt1_d;
      ctr1_q    <= ctr1_d;
      prod2_q   <= prod2_d;
      ctr2_q    <= ctr2_d;
      res3_q    <= res3_d;
      o_pix_q   <= o_pix_d;
      o_valid_q <= o_valid_d;
      hs_q      <= i_hs;
      vs_q      <= i_vs;
    end
  end

  assign o_pix   = o_pix_q;
  assign o_valid = o_valid_q;
  assign o_hs    = hs_q;
  assign o_vs    = vs_q;

endmodule

// File: tb/tb_spr_sharp_apply.sv
module tb_spr_sharp_apply;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_hs = 1'b0;
  logic        i_vs = 1'b0;
  logic        shp_en = 1'b0;
  logic        sharp_bypass = 1'b0;
  logic [11:0] i_pix = '0;
  logic [11:0] amout = '0;
  logic [11:0] o_pix;
  logic        o_valid, o_hs, o_vs;

  int checks = 0;
  int errors = 0;

  logic [11:0] pix_v[$];
  logic [11:0] exp_v[$];

  always #5 clk = ~clk;

  spr_sharp_apply dut (
    .clk          (clk),
    .rst          (rst),
    .i_hs         (i_hs),
    .i_vs         (i_vs),
    .shp_en       (shp_en),
    .sharp_bypass (sharp_bypass),
    .i_pix        (i_pix),
    .amout        (amout),
    .o_pix        (o_pix),
    .o_valid      (o_valid),
    .o_hs         (o_hs),
    .o_vs         (o_vs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Drives ncyc enabled cycles of pix_v (padded with its last value); the result
  // for pixel j must appear after enabled cycle j+7. Optional 3-cycle shp_en stall
  // before enabled cycle stall_at, optional blanking cycle at the end.
  task automatic drive_line(input string nm, input logic [11:0] amt, input logic byp,
                            input int ncyc, input int stall_at, input bit blank);
    logic [11:0] last_out;
    last_out = '0;
    for (int k = 0; k < ncyc; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          i_hs = 1'b1; i_vs = 1'b1; shp_en = 1'b0;
          tick();
          chk($sformatf("%s stall%0d valid", nm, s), 32'(o_valid), 32'd0);
          chk($sformatf("%s stall%0d hold", nm, s), 32'(o_pix), 32'(last_out));
        end
      end
      i_hs = 1'b1; i_vs = 1'b1; shp_en = 1'b1;
      sharp_bypass = byp;
      amout = amt;
      i_pix = (k < pix_v.size()) ? pix_v[k] : pix_v[pix_v.size()-1];
      tick();
      chk($sformatf("%s k%0d valid", nm, k), 32'(o_valid), 32'(k >= 7));
      if (k >= 7 && (k - 7) < exp_v.size()) begin
        chk($sformatf("%s k%0d pix", nm, k), 32'(o_pix), 32'(exp_v[k-7]));
        last_out = exp_v[k-7];
      end
    end
    if (blank) begin
      i_hs = 1'b0; shp_en = 1'b0;
      tick();
      chk({nm, " blank valid"}, 32'(o_valid), 32'd0);
      chk({nm, " blank pix"}, 32'(o_pix), 32'd0);
      chk({nm, " blank hs"}, 32'(o_hs), 32'd0);
      chk({nm, " blank vs"}, 32'(o_vs), 32'd1);
    end
  endtask

  initial begin
    #12;
    chk("reset pix", 32'(o_pix), 32'd0);
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset hs", 32'(o_hs), 32'd0);
    chk("reset vs", 32'(o_vs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Flat line: no edge, output equals input.
    pix_v = {12'd2048};
    exp_v = {12'd2048, 12'd2048, 12'd2048, 12'd2048, 12'd2048};
    drive_line("flat", 12'd1024, 1'b0, 12, -1, 1'b1);

    // Step at unity amount; first pixel uses replicated left neighbour.
    pix_v = {12'd1000, 12'd1000, 12'd2000, 12'd2000, 12'd2000};
    exp_v = {12'd1000, 12'd500, 12'd2500, 12'd2000};
    drive_line("step", 12'd1024, 1'b0, 11, -1, 1'b1);

    // Step at half amount: -250 / +250 with round-half-up on .5 results.
    exp_v = {12'd1000, 12'd750, 12'd2250, 12'd2000};
    drive_line("half", 12'd512, 1'b0, 11, -1, 1'b1);

    // Clamping at both ends.
    pix_v = {12'd0, 12'd0, 12'd4095, 12'd0, 12'd0};
    exp_v = {12'd0, 12'd0, 12'd4095, 12'd0, 12'd0};
    drive_line("clamp", 12'd4095, 1'b0, 12, -1, 1'b1);

    // Bypass returns centre pixel with unchanged latency.
    pix_v = {12'd1000, 12'd1000, 12'd2000, 12'd2000, 12'd2000};
    exp_v = {12'd1000, 12'd1000, 12'd2000, 12'd2000};
    drive_line("bypass", 12'd1024, 1'b1, 11, -1, 1'b1);

    // Mid-line stall: outputs hold, sequence resumes without a gap.
    exp_v = {12'd1000, 12'd500, 12'd2500, 12'd2000};
    drive_line("stall", 12'd1024, 1'b0, 11, 10, 1'b1);

    // Line aborted by i_hs, then a full line restarts cleanly.
    drive_line("abort", 12'd1024, 1'b0, 9, -1, 1'b1);
    drive_line("restart", 12'd1024, 1'b0, 11, -1, 1'b1);

    // Asynchronous reset mid-line, checked before any clock edge.
    drive_line("prerst", 12'd1024, 1'b0, 9, -1, 1'b0);
    rst = 1'b1;
    #1;
    chk("async rst pix", 32'(o_pix), 32'd0);
    chk("async rst valid", 32'(o_valid), 32'd0);
    chk("async rst hs", 32'(o_hs), 32'd0);
    #2;
    rst = 1'b0;
    drive_line("postrst", 12'd1024, 1'b0, 11, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
